wb_port_arbiter: RTL

Shares the single register-file write port between the pipeline write-back path and an out-of-order multi-cycle unit (MDU: multiply/divide).
- Pipeline WB always has priority.
- MDU results are buffered in a small FIFO and drained into idle WB cycles.
- A starvation counter raises a stall request so the FIFO is guaranteed to drain.
- A pending-register query lets the hazard unit detect RAW conflicts on registers still queued.

---
 rtl/wb_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, MDU results queue in a FIFO and drain into idle cycles.
// Optional build macro WB_ARB_BYPASS_EN: an MDU result skips the FIFO when the FIFO is empty and WB is idle.
//
// state | meaning
// RUN   | normal operation; FIFO drains into idle WB cycles
// STALL | FIFO starved for STARVE_MAX cycles; pipe_stall asserted
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        pipe_wreg,
  input  logic [4:0]  pipe_rn,
  input  logic [31:0] pipe_wdi,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rn,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        pipe_stall,
  input  logic [4:0]  q_rn,
  output logic        q_busy,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [4:0]    fifo_rn_q   [DEPTH];
  logic [4:0]    fifo_rn_d   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [0:0]    state_q, state_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_wn_q, rf_wn_d;
  logic [31:0]   rf_d_q, rf_d_d;
  logic          rf_mdu_q, rf_mdu_d;

  logic pipe_sel, fifo_empty, fifo_full, pop, push, bypass, starved;
  logic [AW-1:0] idx;

  always_comb begin
    pipe_sel   = pipe_wreg && (pipe_rn != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (AW+1)'(DEPTH));
    pop        = !pipe_sel && !fifo_empty;
`ifdef WB_ARB_BYPASS_EN
    bypass     = fifo_empty && !pipe_sel && mdu_valid && (mdu_rn != 5'd0);
`else
    bypass     = 1'b0;
`endif
    // rn=0 results still complete the handshake, they just never enter the FIFO
    push       = mdu_valid && !fifo_full && (mdu_rn != 5'd0) && !bypass;
    starved    = !fifo_empty && pipe_sel;
  end

  always_comb begin
    fifo_rn_d   = fifo_rn_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_rn_d[wr_ptr_q]   = mdu_rn;
      fifo_data_d[wr_ptr_q] = mdu_data;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d  = 1'b0;
    rf_wn_d  = rf_wn_q;
    rf_d_d   = rf_d_q;
    rf_mdu_d = 1'b0;
    if (pipe_sel) begin
      rf_we_d = 1'b1;
      rf_wn_d = pipe_rn;
      rf_d_d  = pipe_wdi;
    end else if (pop) begin
      rf_we_d  = 1'b1;
      rf_wn_d  = fifo_rn_q[rd_ptr_q];
      rf_d_d   = fifo_data_q[rd_ptr_q];
      rf_mdu_d = 1'b1;
    end else if (bypass) begin
      rf_we_d  = 1'b1;
      rf_wn_d  = mdu_rn;
      rf_d_d   = mdu_data;
      rf_mdu_d = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) starve_d = '0;
    else if (starved && (starve_q != CW'(STARVE_MAX))) starve_d = starve_q + CW'(1);

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (starved && (starve_q == CW'(STARVE_MAX - 1))) state_d = ST_STALL;
      ST_STALL: if (pop || fifo_empty) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Busy if queued, or currently being written by an MDU-sourced write
  always_comb begin
    q_busy = 1'b0;
    idx    = rd_ptr_q;
    if (q_rn != 5'd0) begin
      if (rf_we_q && rf_mdu_q && (rf_wn_q == q_rn)) q_busy = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + AW'(k);
        if (((AW+1)'(k) < count_q) && (fifo_rn_q[idx] == q_rn)) q_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rn_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      state_q  <= ST_RUN;
      rf_we_q  <= 1'b0;
      rf_wn_q  <= '0;
      rf_d_q   <= '0;
      rf_mdu_q <= 1'b0;
    end else begin
      fifo_rn_q   <= fifo_rn_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_wn_q     <= rf_wn_d;
      rf_d_q      <= rf_d_d;
      rf_mdu_q    <= rf_mdu_d;
    end
  end

  assign mdu_ready  = (count_q != (AW+1)'(DEPTH));
  assign pipe_stall = (state_q == ST_STALL);
  assign rf_we      = rf_we_q;
  assign rf_wn      = rf_wn_q;
  assign rf_d       = rf_d_q;

endmodule
